// File: rtl/tri_assignment_pipe.sv
// Applies one of AND/OR/XOR/ADD per lane and presents the result combinationally,
// registered once, and through a DEPTH-stage valid-tagged pipeline with a beat counter.
module tri_assignment_pipe #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [1:0]                op,
    input  logic [CHANNELS*WIDTH-1:0] a,
    input  logic [CHANNELS*WIDTH-1:0] b,
    output logic [CHANNELS*WIDTH-1:0] c1,
    output logic [CHANNELS*WIDTH-1:0] c2,
    output logic                      c2_valid,
    output logic [CHANNELS*WIDTH-1:0] c3,
    output logic [CHANNELS-1:0]       c3_carry,
    output logic                      c3_valid,
    output logic [15:0]               done_cnt
);

    localparam int LW = CHANNELS * WIDTH;

    logic [LW-1:0]       f_next;
    logic [CHANNELS-1:0] carry_next;

    // Each lane has its own adder so carries never cross lane boundaries.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
            logic [WIDTH-1:0] a_lane;
            logic [WIDTH-1:0] b_lane;
            logic [WIDTH:0]   sum_lane;
            logic [WIDTH-1:0] f_lane;
            logic             carry_lane;

            assign a_lane   = a[gi*WIDTH +: WIDTH];
            assign b_lane   = b[gi*WIDTH +: WIDTH];
            assign sum_lane = {1'b0, a_lane} + {1'b0, b_lane};

            always_comb begin
                f_lane     = '0;
                carry_lane = 1'b0;
                case (op)
                    2'd0: f_lane = a_lane & b_lane;
                    2'd1: f_lane = a_lane | b_lane;
                    2'd2: f_lane = a_lane ^ b_lane;
                    default: begin
                        f_lane     = sum_lane[WIDTH-1:0];
                        carry_lane = sum_lane[WIDTH];
                    end
                endcase
            end

            assign f_next[gi*WIDTH +: WIDTH] = f_lane;
            assign carry_next[gi]            = carry_lane;
        end
    endgenerate

    assign c1 = f_next;

    logic [LW-1:0] c2_reg;
    logic          c2_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            c2_reg       <= '0;
            c2_valid_reg <= 1'b0;
        end else begin
            c2_valid_reg <= in_valid;
            if (in_valid) begin
                c2_reg <= f_next;
            end
        end
    end

    assign c2       = c2_reg;
    assign c2_valid = c2_valid_reg;

    logic [LW-1:0]       data_reg  [DEPTH];
    logic [CHANNELS-1:0] carry_reg [DEPTH];
    logic [DEPTH-1:0]    valid_reg;

    // Free-running shift register: invalid slots enter as zeroed bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                data_reg[s]  <= '0;
                carry_reg[s] <= '0;
            end
            valid_reg <= '0;
        end else begin
            data_reg[0]  <= in_valid ? f_next : '0;
            carry_reg[0] <= in_valid ? carry_next : '0;
            valid_reg[0] <= in_valid;
            for (int s = 1; s < DEPTH; s++) begin
                data_reg[s]  <= data_reg[s-1];
                carry_reg[s] <= carry_reg[s-1];
                valid_reg[s] <= valid_reg[s-1];
            end
        end
    end

    assign c3       = data_reg[DEPTH-1];
    assign c3_carry = carry_reg[DEPTH-1];
    assign c3_valid = valid_reg[DEPTH-1];

    logic [15:0] done_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt_reg <= '0;
        end else if (c3_valid && (done_cnt_reg != 16'hFFFF)) begin
            done_cnt_reg <= done_cnt_reg + 16'd1;
        end
    end

    assign done_cnt = done_cnt_reg;

endmodule

// File: tb/tb_tri_assignment_pipe.sv
// Directed bench for tri_assignment_pipe (WIDTH=8, CHANNELS=2, DEPTH=3) with
// hand-computed expectations checked through immediate assertions.
module tb_tri_assignment_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c1;
    logic [15:0] c2;
    logic        c2_valid;
    logic [15:0] c3;
    logic [1:0]  c3_carry;
    logic        c3_valid;
    logic [15:0] done_cnt;

    int errors = 0;
    int checks = 0;

    tri_assignment_pipe #(.WIDTH(8), .CHANNELS(2), .DEPTH(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .op       (op),
        .a        (a),
        .b        (b),
        .c1       (c1),
        .c2       (c2),
        .c2_valid (c2_valid),
        .c3       (c3),
        .c3_carry (c3_carry),
        .c3_valid (c3_valid),
        .done_cnt (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic v, input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv);
        in_valid = v;
        op       = o;
        a        = av;
        b        = bv;
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = 2'd0; a = '0; b = '0;
        tick(2);
        rst = 1'b0;
        check("rst_c2", c2, 0);
        check("rst_c2_valid", c2_valid, 0);
        check("rst_c3", c3, 0);
        check("rst_c3_carry", c3_carry, 0);
        check("rst_c3_valid", c3_valid, 0);
        check("rst_done_cnt", done_cnt, 0);

        // Logic ops, back to back
        beat(1, 2'd0, 16'h0FF0, 16'h3C3C); check("and_c1", c1, 16'h0C30);
        tick(1); check("and_c2", c2, 16'h0C30); check("and_c2_valid", c2_valid, 1);
        beat(1, 2'd1, 16'h0FF0, 16'h3C3C); check("or_c1", c1, 16'h3FFC);
        tick(1); check("or_c2", c2, 16'h3FFC);
        beat(1, 2'd2, 16'h0FF0, 16'h3C3C); check("xor_c1", c1, 16'h33CC);
        tick(1); check("xor_c2", c2, 16'h33CC);
        check("and_c3", c3, 16'h0C30); check("and_c3_valid", c3_valid, 1); check("and_c3_carry", c3_carry, 0);
        beat(0, 2'd2, 16'h0FF0, 16'h3C3C);
        tick(1); check("hold_c2", c2, 16'h33CC); check("hold_c2_valid", c2_valid, 0);
        check("or_c3", c3, 16'h3FFC); check("or_c3_valid", c3_valid, 1);
        tick(1); check("xor_c3", c3, 16'h33CC); check("xor_c3_valid", c3_valid, 1);
        tick(1); check("drain_c3", c3, 0); check("drain_c3_valid", c3_valid, 0);
        check("cnt_after_ops", done_cnt, 3);

        // ADD wrap with per-lane isolation
        beat(1, 2'd3, 16'hFF01, 16'h0102); check("add_c1", c1, 16'h0003);
        tick(1); beat(0, 2'd0, 16'h0000, 16'h0000);
        check("add_c2", c2, 16'h0003);
        tick(1); check("add_early_valid", c3_valid, 0);
        tick(1); check("add_c3", c3, 16'h0003); check("add_c3_carry", c3_carry, 2'b10);
        check("add_c3_valid", c3_valid, 1);
        tick(1); check("add_bubble_carry", c3_carry, 0);
        check("cnt_after_add", done_cnt, 4);

        // Bubble pattern 1,0,1,1
        beat(1, 2'd2, 16'h0001, 16'h0000);
        tick(1); beat(0, 2'd2, 16'h00FF, 16'h0000);
        tick(1); check("bub_c2_hold", c2, 16'h0001); check("bub_c2_valid", c2_valid, 0);
        beat(1, 2'd2, 16'h0002, 16'h0000);
        tick(1); check("bub_s0_c3", c3, 16'h0001); check("bub_s0_valid", c3_valid, 1);
        beat(1, 2'd2, 16'h0003, 16'h0000);
        tick(1); check("bub_s1_c3", c3, 0); check("bub_s1_valid", c3_valid, 0);
        beat(0, 2'd0, 16'h0000, 16'h0000);
        tick(1); check("bub_s2_c3", c3, 16'h0002); check("bub_s2_valid", c3_valid, 1);
        tick(1); check("bub_s3_c3", c3, 16'h0003); check("bub_s3_valid", c3_valid, 1);
        tick(1); check("bub_end_valid", c3_valid, 0);
        check("cnt_after_bub", done_cnt, 7);

        // Reset with two beats in flight
        beat(1, 2'd1, 16'h1111, 16'h0000);
        tick(1); beat(1, 2'd1, 16'h2222, 16'h0000);
        tick(1); beat(0, 2'd0, 16'h0000, 16'h0000); rst = 1'b1;
        tick(1); rst = 1'b0;
        check("mid_c2", c2, 0); check("mid_c2_valid", c2_valid, 0);
        check("mid_c3", c3, 0); check("mid_c3_valid", c3_valid, 0);
        check("mid_done_cnt", done_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1); check("mid_no_valid", c3_valid, 0);
        end
        check("mid_cnt_final", done_cnt, 0);

        // Reset priority over in_valid
        rst = 1'b1; beat(1, 2'd1, 16'h5555, 16'h0000);
        tick(1); rst = 1'b0; beat(0, 2'd0, 16'h0000, 16'h0000);
        check("prio_c2_valid", c2_valid, 0); check("prio_c2", c2, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1); check("prio_no_valid", c3_valid, 0);
        end
        check("prio_cnt", done_cnt, 0);

        // Saturation: 65540 back-to-back beats
        beat(1, 2'd0, 16'hFFFF, 16'hFFFF);
        tick(65540);
        beat(0, 2'd0, 16'h0000, 16'h0000);
        tick(3);
        check("sat_done_cnt", done_cnt, 16'hFFFF);
        tick(5);
        check("sat_hold", done_cnt, 16'hFFFF);
        rst = 1'b1;
        tick(1); rst = 1'b0;
        check("sat_rst", done_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
